// File: rtl/regfile_debug_pkg.sv
//==============================================================================
// Module : regfile_debug_pkg
// Brief  : Shared types and defaults for the register file debug port.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package regfile_debug_pkg;

    localparam int C_NUM_REGS = 32;
    localparam int C_XLEN     = 64;
    localparam int C_ADDR_W   = 5;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_DUMP  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_ACCESS    = 3'd1;
    localparam state_t ST_RESP      = 3'd2;
    localparam state_t ST_DUMP_SEL  = 3'd3;
    localparam state_t ST_DUMP_RESP = 3'd4;

endpackage

`default_nettype wire

// File: rtl/regfile_debug_port.sv
//==============================================================================
// Module : regfile_debug_port
// Brief  : Command/response agent driving register file ports for debug access.
//          Optional full-file dump enabled by defining REGFILE_DEBUG_DUMP_EN.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module regfile_debug_port
    import regfile_debug_pkg::*;
#(
    parameter int NUM_REGS = C_NUM_REGS,
    parameter int XLEN     = C_XLEN,
    parameter int ADDR_W   = C_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [XLEN-1:0]   cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [XLEN-1:0]   rsp_data,
    output logic              rsp_err,
    output logic              rsp_last,
    output logic [ADDR_W-1:0] rf_read_select,
    input  logic [XLEN-1:0]   rf_read_data,
    output logic              rf_write_enable,
    output logic [ADDR_W-1:0] rf_write_select,
    output logic [XLEN-1:0]   rf_write_data,
    output logic              busy
);

    localparam logic [ADDR_W:0]   c_num_regs = (ADDR_W+1)'(NUM_REGS);
`ifdef REGFILE_DEBUG_DUMP_EN
    localparam logic [ADDR_W-1:0] c_last_idx = ADDR_W'(NUM_REGS - 1);
`endif

    state_t            r_state;
    op_e               r_op;
    logic [ADDR_W-1:0] r_addr;   // also serves as the dump index
    logic [XLEN-1:0]   r_data;
    logic              r_rsp_valid;
    logic [ADDR_W-1:0] r_rsp_addr;
    logic [XLEN-1:0]   r_rsp_data;
    logic              r_rsp_err;
    logic              r_rsp_last;

    logic              w_err;
    logic              w_read_ok;
    logic              w_idle;

    always_comb begin
        w_err = 1'b0;
        if (r_op == OP_RSVD)
            w_err = 1'b1;
`ifndef REGFILE_DEBUG_DUMP_EN
        if (r_op == OP_DUMP)
            w_err = 1'b1;
`endif
        if ({1'b0, r_addr} >= c_num_regs)
            w_err = 1'b1;
        if ((r_op == OP_WRITE) && (r_addr == '0))
            w_err = 1'b1;
    end

    // Register 0 is hardwired zero, so its read data is never forwarded.
    assign w_read_ok = (r_op == OP_READ) && !w_err && (r_addr != '0);
    assign w_idle    = (r_state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_READ;
            r_addr      <= '0;
            r_data      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_addr  <= '0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op   <= op_e'(cmd_op);
                        r_addr <= cmd_addr;
                        r_data <= cmd_data;
`ifdef REGFILE_DEBUG_DUMP_EN
                        if (op_e'(cmd_op) == OP_DUMP) begin
                            r_addr  <= '0;
                            r_state <= ST_DUMP_SEL;
                        end else begin
                            r_state <= ST_ACCESS;
                        end
`else
                        r_state <= ST_ACCESS;
`endif
                    end
                end
                ST_ACCESS: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_addr  <= r_addr;
                    r_rsp_data  <= w_read_ok ? rf_read_data : '0;
                    r_rsp_err   <= w_err;
                    r_rsp_last  <= 1'b1;
                    r_state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
`ifdef REGFILE_DEBUG_DUMP_EN
                ST_DUMP_SEL: begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_addr  <= r_addr;
                    r_rsp_data  <= (r_addr == '0) ? '0 : rf_read_data;
                    r_rsp_err   <= 1'b0;
                    r_rsp_last  <= (r_addr == c_last_idx);
                    r_state     <= ST_DUMP_RESP;
                end
                ST_DUMP_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rsp_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_addr  <= r_addr + ADDR_W'(1);
                            r_state <= ST_DUMP_SEL;
                        end
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready       = w_idle;
    assign busy            = !w_idle;
    assign rsp_valid       = r_rsp_valid;
    assign rsp_addr        = r_rsp_addr;
    assign rsp_data        = r_rsp_data;
    assign rsp_err         = r_rsp_err;
    assign rsp_last        = r_rsp_last;
    assign rf_read_select  = w_idle ? '0 : r_addr;
    assign rf_write_select = r_addr;
    assign rf_write_data   = r_data;
    // Reset gates the strobe directly so a write in flight is dropped that edge.
    assign rf_write_enable = (r_state == ST_ACCESS) && (r_op == OP_WRITE) && !w_err && !reset;

endmodule

`default_nettype wire

// File: tb/tb_regfile_debug_port.sv
//==============================================================================
// Module : tb_regfile_debug_port
// Brief  : Self-checking bench for regfile_debug_port with a register file model.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_regfile_debug_port;

    localparam int NR = 32;
    localparam int XL = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [XL-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [AW-1:0] rsp_addr;
    logic [XL-1:0] rsp_data;
    logic          rsp_err;
    logic          rsp_last;
    logic [AW-1:0] rf_read_select;
    logic [XL-1:0] rf_read_data;
    logic          rf_write_enable;
    logic [AW-1:0] rf_write_select;
    logic [XL-1:0] rf_write_data;
    logic          busy;

    always #5 clk = ~clk;

    regfile_debug_port #(.NUM_REGS(NR), .XLEN(XL), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_last(rsp_last),
        .rf_read_select(rf_read_select), .rf_read_data(rf_read_data),
        .rf_write_enable(rf_write_enable), .rf_write_select(rf_write_select),
        .rf_write_data(rf_write_data), .busy(busy)
    );

    // External register file; reg 0 reads all ones so forced-zero reads are visible.
    logic [XL-1:0] rf [NR];
    logic          dump_mode = 1'b0;
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NR; i++) rf[i] <= '0;
            rf[0] <= '1;
        end else if (rf_write_enable) begin
            rf[rf_write_select] <= rf_write_data;
        end
    end
    assign rf_read_data = (dump_mode && rf_read_select != '0) ?
                          64'(rf_read_select) * 64'h11 : rf[rf_read_select];

    logic rdy_manual = 1'b1;
    logic rnd_mode   = 1'b0;
    logic rnd_bit    = 1'b1;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign rsp_ready = rnd_mode ? rnd_bit : rdy_manual;

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [XL-1:0] data;
        logic          err;
        logic          last;
    } rsp_t;
    rsp_t sb[$];

    always @(negedge clk) begin
        if (!reset && rf_write_enable) we_cnt++;
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_rsp: got addr %0d with empty scoreboard", rsp_addr);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                chk("rsp_addr", 64'(rsp_addr), 64'(e.addr));
                chk("rsp_data", rsp_data, e.data);
                chk("rsp_err",  64'(rsp_err),  64'(e.err));
                chk("rsp_last", 64'(rsp_last), 64'(e.last));
            end
        end
    end

    task automatic push(input logic [AW-1:0] a, input logic [XL-1:0] d, input logic e, input logic l);
        rsp_t r;
        r.addr = a; r.data = d; r.err = e; r.last = l;
        sb.push_back(r);
    endtask

    // Returns #1 after the accepting edge, i.e. inside the ACCESS cycle.
    task automatic issue(input logic [1:0] op, input logic [AW-1:0] a, input logic [XL-1:0] d);
        int n = 0;
        @(posedge clk); #1;
        while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
        if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin @(posedge clk); n++; end
        if (sb.size() != 0) begin
            chk("drain_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [XL-1:0] wdata;
        logic          err;
        logic [XL-1:0] rdata;
    } vec_t;
    vec_t vt[10];

    initial begin
        int c0;
        vt[0] = '{2'd0, 5'd5,  64'h0,                   1'b0, 64'hDEADBEEF_CAFEF00D};
        vt[1] = '{2'd1, 5'd0,  64'h1234,                1'b1, 64'h0};
        vt[2] = '{2'd3, 5'd7,  64'h77,                  1'b1, 64'h0};
        vt[3] = '{2'd0, 5'd0,  64'h0,                   1'b0, 64'h0};
        vt[4] = '{2'd1, 5'd31, 64'h01234567_89ABCDEF,   1'b0, 64'h0};
        vt[5] = '{2'd0, 5'd31, 64'h0,                   1'b0, 64'h01234567_89ABCDEF};
        vt[6] = '{2'd1, 5'd1,  64'hA5A5A5A5_5A5A5A5A,   1'b0, 64'h0};
        vt[7] = '{2'd0, 5'd1,  64'h0,                   1'b0, 64'hA5A5A5A5_5A5A5A5A};
        vt[8] = '{2'd0, 5'd2,  64'h0,                   1'b0, 64'h0};
        vt[9] = '{2'd0, 5'd31, 64'h0,                   1'b0, 64'h01234567_89ABCDEF};

        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = '0; cmd_data = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_we",        64'(rf_write_enable), 64'd0);
        chk("rst_busy",      64'(busy), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_rsp_data",  rsp_data, 64'd0);
        chk("rst_rd_sel",    64'(rf_read_select), 64'd0);
        chk("rst_wr_sel",    64'(rf_write_select), 64'd0);

        // WRITE 5: strobe in ACCESS only, ack in RESP.
        c0 = we_cnt;
        push(5'd5, 64'h0, 1'b0, 1'b1);
        issue(2'd1, 5'd5, 64'hDEADBEEF_CAFEF00D);
        @(negedge clk);
        chk("wr_t1_we",    64'(rf_write_enable), 64'd1);
        chk("wr_t1_sel",   64'(rf_write_select), 64'd5);
        chk("wr_t1_data",  rf_write_data, 64'hDEADBEEF_CAFEF00D);
        chk("wr_t1_valid", 64'(rsp_valid), 64'd0);
        chk("wr_t1_busy",  64'(busy), 64'd1);
        @(negedge clk);
        chk("wr_t2_we",    64'(rf_write_enable), 64'd0);
        chk("wr_t2_valid", 64'(rsp_valid), 64'd1);
        @(negedge clk);
        chk("wr_t3_ready", 64'(cmd_ready), 64'd1);
        chk("wr_we_count", 64'(we_cnt - c0), 64'd1);

        for (int i = 0; i < 10; i++) begin
            c0 = we_cnt;
            push(vt[i].addr, vt[i].rdata, vt[i].err, 1'b1);
            issue(vt[i].op, vt[i].addr, vt[i].wdata);
            drain(200);
            chk("vec_we_count", 64'(we_cnt - c0),
                64'((vt[i].op == 2'd1) && !vt[i].err));
        end

        // READ 5 with response backpressure; a stray command must be ignored.
        c0 = we_cnt;
        rdy_manual = 1'b0;
        push(5'd5, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b1);
        issue(2'd0, 5'd5, 64'h0);
        @(negedge clk);
        chk("stall_t1_valid", 64'(rsp_valid), 64'd0);
        cmd_valid = 1'b1; cmd_op = 2'd1; cmd_addr = 5'd9; cmd_data = 64'hBAD0BAD0_BAD0BAD0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_valid", 64'(rsp_valid), 64'd1);
            chk("stall_data",  rsp_data, 64'hDEADBEEF_CAFEF00D);
            chk("stall_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        cmd_valid = 1'b0;
        rdy_manual = 1'b1;
        drain(200);
        chk("stall_we_count", 64'(we_cnt - c0), 64'd0);
        chk("stall_rf9", rf[9], 64'd0);

        // Reset sampled in the ACCESS cycle of a WRITE drops the write.
        c0 = we_cnt;
        issue(2'd1, 5'd12, 64'h12121212_12121212);
        reset = 1'b1;
        @(negedge clk);
        chk("rstmid_we", 64'(rf_write_enable), 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rstmid_valid", 64'(rsp_valid), 64'd0);
        chk("rstmid_busy",  64'(busy), 64'd0);
        chk("rstmid_ready", 64'(cmd_ready), 64'd1);
        chk("rstmid_we_count", 64'(we_cnt - c0), 64'd0);

`ifdef REGFILE_DEBUG_DUMP_EN
        dump_mode = 1'b1;
        rnd_mode  = 1'b1;
        for (int i = 0; i < NR; i++)
            push(AW'(i), (i == 0) ? 64'h0 : 64'(i) * 64'h11, 1'b0, (i == NR - 1));
        issue(2'd2, 5'd17, 64'h0);
        drain(2000);
        rnd_mode  = 1'b0;
        dump_mode = 1'b0;
        @(negedge clk);
        chk("dump_end_ready", 64'(cmd_ready), 64'd1);
`else
        c0 = we_cnt;
        push(5'd3, 64'h0, 1'b1, 1'b1);
        issue(2'd2, 5'd3, 64'h33);
        drain(200);
        chk("op2_we_count", 64'(we_cnt - c0), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
